// File: rtl/h_timing_gen_if.sv
// h_timing_gen_if
// Bundles the horizontal timing stage's run control and its outputs.
//   enable   : run; low freezes the timing stage
//   pix_en   : pixel-clock enable, one clk wide
//   h_value  : current pixel column
//   hsync    : horizontal sync
//   h_active : column lies in the visible region
//   v_enable : end-of-line strobe for the vertical counter
// master = whoever drives enable (controller / bench), slave = h_timing_gen.
interface h_timing_gen_if #(
  parameter int HW = 11
);
  logic          enable;
  logic          pix_en;
  logic [HW-1:0] h_value;
  logic          hsync;
  logic          h_active;
  logic          v_enable;

  modport master (
    output enable,
    input  pix_en, h_value, hsync, h_active, v_enable
  );

  modport slave (
    input  enable,
    output pix_en, h_value, hsync, h_active, v_enable
  );
endinterface

// File: rtl/h_timing_gen.sv
// h_timing_gen
// Horizontal timing stage of the VGA controller. Divides clk into a pixel
// enable, walks the pixel column across a full scan line and decodes hsync,
// the active-video flag and the one-cycle end-of-line strobe (v_enable)
// that steps the vertical counter.
// Ports:
//   clk  : system clock
//   rst  : asynchronous, active-high reset
//   tim  : h_timing_gen_if slave (enable in; pix_en, h_value, hsync,
//          h_active, v_enable out)
//
// state  | meaning
// -------+-----------------------------------------------
// ACTIVE | visible pixels, h 0..H_ACTIVE-1
// FRONT  | front porch
// SYNC   | sync pulse, hsync = SYNC_POL
// BACK   | back porch, up to MAX_H
module h_timing_gen #(
  parameter int MAX_H    = 799,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int CLK_DIV  = 2,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  h_timing_gen_if.slave tim
);

  localparam int HW = $clog2(MAX_H) + 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST     = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST       = HW'(MAX_H);
  localparam logic [HW-1:0] H_FRONT_BEG  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG   = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] H_BACK_BEG   = HW'(H_ACTIVE + H_FRONT + H_SYNC);

  if (H_ACTIVE + H_FRONT + H_SYNC + H_BACK != MAX_H + 1) begin : g_bad_line
    $fatal(1, "h_timing_gen: H_ACTIVE+H_FRONT+H_SYNC+H_BACK must equal MAX_H+1");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $fatal(1, "h_timing_gen: CLK_DIV must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FRONT  = 2'd1,
    ST_SYNC   = 2'd2,
    ST_BACK   = 2'd3
  } phase_e;

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] h_q, h_d;
  phase_e        state_q, state_d;
  logic          pix_en;

  // rst is folded in so pix_en (and v_enable) drop the moment reset asserts,
  // which matters with CLK_DIV=1 where div_q==DIV_LAST holds even in reset.
  assign pix_en = tim.enable && !rst && (div_q == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      h_q     <= '0;
      state_q <= ST_ACTIVE;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    div_d = div_q;
    if (tim.enable) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end
  end

  always_comb begin
    h_d = h_q;
    if (pix_en) begin
      h_d = (h_q == H_LAST) ? '0 : h_q + 1'b1;
    end
  end

  // Transitions look at the next column so the phase always matches h_q.
  always_comb begin
    state_d = state_q;
    if (pix_en) begin
      case (state_q)
        ST_ACTIVE: if (h_d == H_FRONT_BEG) state_d = ST_FRONT;
        ST_FRONT:  if (h_d == H_SYNC_BEG)  state_d = ST_SYNC;
        ST_SYNC:   if (h_d == H_BACK_BEG)  state_d = ST_BACK;
        ST_BACK:   if (h_d == '0)          state_d = ST_ACTIVE;
        default:                           state_d = ST_ACTIVE;
      endcase
    end
  end

  assign tim.pix_en   = pix_en;
  assign tim.h_value  = h_q;
  assign tim.h_active = (state_q == ST_ACTIVE);
  assign tim.hsync    = (state_q == ST_SYNC) ? SYNC_POL : !SYNC_POL;
  assign tim.v_enable = pix_en && (h_q == H_LAST);

endmodule
